// File: rtl/apb_pkg.sv
// Shared types and constants for the APB completer port.
package apb_pkg;

    // Transfer sequencing states of the completer FSM
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        HOLD = 2'd3
    } state_t;

    // Address field positions inside addr_in
    localparam int PORT_MSB = 10;
    localparam int PORT_LSB = 8;
    localparam int IDX_MSB  = 7;
    localparam int IDX_LSB  = 2;

    // Peripheral select codes on sel_port
    localparam logic [2:0] GPIO  = 3'd2;
    localparam logic [2:0] UART  = 3'd3;
    localparam logic [2:0] TIMER = 3'd4;
    localparam logic [2:0] I2C   = 3'd5;
    localparam logic [2:0] SPI   = 3'd6;
    localparam logic [2:0] PWM   = 3'd7;

    // Word index field of the low address byte
    function automatic logic [5:0] addr_idx(input logic [7:0] addr);
        return addr[IDX_MSB:IDX_LSB];
    endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Bank of NUM_REGS 32-bit read/write registers with a single write port,
// a combinational read mux and a flat view of all contents.
module apb_reg_bank #(
    parameter int          NUM_REGS  = 4,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [5:0]              widx,
    input  logic [31:0]             wdata,
    input  logic [5:0]              ridx,
    output logic [31:0]             rdata,
    output logic [NUM_REGS*32-1:0]  regs_flat
);

    logic [31:0] regs_r [NUM_REGS];

    // Register storage: reset to RESET_VAL, write the addressed word
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_r[k] <= RESET_VAL;
            end
        end else if (we) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (widx == 6'(k)) begin
                    regs_r[k] <= wdata;
                end
            end
        end
    end

    // Read mux: out-of-range indices read as zero
    always_comb begin
        rdata = 32'h0;
        for (int k = 0; k < NUM_REGS; k++) begin
            rdata = (ridx == 6'(k)) ? regs_r[k] : rdata;
        end
    end

    // Flatten the array so reg k sits at bits [32k+31:32k]
    always_comb begin
        regs_flat = {(NUM_REGS*32){1'b0}};
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_flat[32*k +: 32] = regs_r[k];
        end
    end

endmodule

// File: rtl/apb_slave_port.sv
// APB completer: decodes its port ID, inserts WAIT_CYCLES wait states,
// accesses a local register bank plus one read-only status word, and
// answers with a one-cycle ready pulse carrying rdata or slv_err.
module apb_slave_port
    import apb_pkg::*;
#(
    parameter logic [2:0]  PORT_ID     = 3'd2,
    parameter int          NUM_REGS    = 4,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] RESET_VAL   = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             sel_port,
    input  logic                   en,
    input  logic                   wr_in,
    input  logic [11:0]            addr_in,
    input  logic [31:0]            data_in,
    input  logic [31:0]            sts_in,
    output logic                   ready,
    output logic [31:0]            rdata,
    output logic                   slv_err,
    output logic [NUM_REGS*32-1:0] regs_out
);

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);
    localparam logic [5:0] STS_IDX  = 6'(NUM_REGS);

    state_t      state_r, state_nxt_s;
    logic [3:0]  cnt_r;
    logic [7:0]  addr_r;
    logic        wr_r;
    logic [31:0] data_r;
    logic        ready_r;
    logic [31:0] rdata_r;
    logic        slv_err_r;

    logic        hit_s;
    logic        commit_s;
    logic        we_s;
    logic        err_s;
    logic [5:0]  idx_s;
    logic [31:0] bank_rdata_s;
    logic [31:0] rd_val_s;
    logic        unused_addr_s;

    // The port field duplicates sel_port; decode relies on sel_port alone
    assign unused_addr_s = ^{addr_in[11], addr_in[PORT_MSB:PORT_LSB]};

    assign hit_s = (sel_port == PORT_ID) && en;

    apb_reg_bank #(
        .NUM_REGS  (NUM_REGS),
        .RESET_VAL (RESET_VAL)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .we        (we_s),
        .widx      (idx_s),
        .wdata     (data_r),
        .ridx      (idx_s),
        .rdata     (bank_rdata_s),
        .regs_flat (regs_out)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; HOLD waits for en low so a held request is served once
    always_comb begin
        state_nxt_s = IDLE;
        case (state_r)
            IDLE: begin
                if (hit_s) state_nxt_s = WAIT;
                else       state_nxt_s = IDLE;
            end
            WAIT: begin
                if (!hit_s)               state_nxt_s = IDLE;
                else if (cnt_r != 4'd0)   state_nxt_s = WAIT;
                else                      state_nxt_s = RESP;
            end
            RESP: state_nxt_s = HOLD;
            HOLD: begin
                if (!en) state_nxt_s = IDLE;
                else     state_nxt_s = HOLD;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Commit strobe and address decode of the latched request
    always_comb begin
        commit_s = (state_r == WAIT) && hit_s && (cnt_r == 4'd0);
        idx_s    = addr_idx(addr_r);
        we_s     = 1'b0;
        err_s    = 1'b0;
        rd_val_s = 32'h0;
        if (addr_r[1:0] != 2'b00) begin
            err_s = 1'b1;
        end else if (idx_s < STS_IDX) begin
            we_s     = commit_s && wr_r;
            rd_val_s = bank_rdata_s;
        end else if (idx_s == STS_IDX) begin
            err_s    = wr_r;
            rd_val_s = sts_in;
        end else begin
            err_s = 1'b1;
        end
    end

    // Request latch, wait counter and registered response outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r     <= 4'd0;
            addr_r    <= 8'h0;
            wr_r      <= 1'b0;
            data_r    <= 32'h0;
            ready_r   <= 1'b0;
            rdata_r   <= 32'h0;
            slv_err_r <= 1'b0;
        end else begin
            ready_r <= commit_s;
            if (state_r == IDLE && hit_s) begin
                addr_r <= addr_in[7:0];
                wr_r   <= wr_in;
                data_r <= data_in;
                cnt_r  <= CNT_INIT;
            end else if (state_r == WAIT && hit_s && cnt_r != 4'd0) begin
                cnt_r <= cnt_r - 4'd1;
            end
            if (commit_s) begin
                rdata_r   <= err_s ? 32'h0 : (wr_r ? 32'h0 : rd_val_s);
                slv_err_r <= err_s;
            end else if (state_r == RESP) begin
                rdata_r   <= 32'h0;
                slv_err_r <= 1'b0;
            end
        end
    end

    assign ready   = ready_r;
    assign rdata   = rdata_r;
    assign slv_err = slv_err_r;

endmodule

// File: tb/tb_apb_slave_port.sv
// Scoreboard bench: three completers (wait states 0/3/4) share one APB bus.
module tb_apb_slave_port;

    typedef struct {
        int          dut;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    localparam logic [2:0]  PORTS [3] = '{3'd2, 3'd4, 3'd5};
    localparam int          WAITS [3] = '{0, 3, 4};
    localparam logic [31:0] RVALS [3] = '{32'h0, 32'hCAFE_0003, 32'h0000_5555};

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  sel_port;
    logic        en;
    logic        wr_in;
    logic [11:0] addr_in;
    logic [31:0] data_in;
    logic [31:0] sts_in;

    logic         ready_a [3];
    logic [31:0]  rdata_a [3];
    logic         err_a   [3];
    logic [127:0] regs_a  [3];

    logic [31:0] mdl [3][4];
    exp_t        exp_q [$];
    int          ready_cnt [3] = '{0, 0, 0};
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    apb_slave_port #(.PORT_ID(3'd2), .NUM_REGS(4), .WAIT_CYCLES(0), .RESET_VAL(32'h0)) dut0 (
        .clk(clk), .rst(rst), .sel_port(sel_port), .en(en), .wr_in(wr_in),
        .addr_in(addr_in), .data_in(data_in), .sts_in(sts_in),
        .ready(ready_a[0]), .rdata(rdata_a[0]), .slv_err(err_a[0]), .regs_out(regs_a[0]));

    apb_slave_port #(.PORT_ID(3'd4), .NUM_REGS(4), .WAIT_CYCLES(3), .RESET_VAL(32'hCAFE_0003)) dut3 (
        .clk(clk), .rst(rst), .sel_port(sel_port), .en(en), .wr_in(wr_in),
        .addr_in(addr_in), .data_in(data_in), .sts_in(sts_in),
        .ready(ready_a[1]), .rdata(rdata_a[1]), .slv_err(err_a[1]), .regs_out(regs_a[1]));

    apb_slave_port #(.PORT_ID(3'd5), .NUM_REGS(4), .WAIT_CYCLES(4), .RESET_VAL(32'h0000_5555)) dut4 (
        .clk(clk), .rst(rst), .sel_port(sel_port), .en(en), .wr_in(wr_in),
        .addr_in(addr_in), .data_in(data_in), .sts_in(sts_in),
        .ready(ready_a[2]), .rdata(rdata_a[2]), .slv_err(err_a[2]), .regs_out(regs_a[2]));

    // Count ready pulses per completer
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ready_a[i]) ready_cnt[i] <= ready_cnt[i] + 1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] flat(input int d);
        return {mdl[d][3], mdl[d][2], mdl[d][1], mdl[d][0]};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++)
            for (int k = 0; k < 4; k++) mdl[d][k] = RVALS[d];
    endtask

    task automatic check_idle_all(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk({tag, "_ready"}, 128'(ready_a[d]), 128'(0));
            chk({tag, "_rdata"}, 128'(rdata_a[d]), 128'(0));
            chk({tag, "_err"},   128'(err_a[d]),   128'(0));
            chk({tag, "_regs"},  regs_a[d],        flat(d));
        end
    endtask

    // One transfer on completer d; en held for `hold` cycles after ready
    task automatic xfer(input int d, input logic w, input logic [11:0] a,
                        input logic [31:0] wd, input int hold);
        exp_t e;
        exp_t g;
        int lat;
        int c0 [3];
        logic [5:0] idx;
        for (int i = 0; i < 3; i++) c0[i] = ready_cnt[i];
        idx     = a[7:2];
        e.dut   = d;
        e.err   = 1'b0;
        e.rdata = 32'h0;
        if (a[1:0] != 2'b00 || idx > 6'd4) begin
            e.err = 1'b1;
        end else if (idx == 6'd4) begin
            if (w) e.err = 1'b1;
            else   e.rdata = sts_in;
        end else if (w) begin
            mdl[d][idx[1:0]] = wd;
        end else begin
            e.rdata = mdl[d][idx[1:0]];
        end
        exp_q.push_back(e);

        @(negedge clk);
        sel_port = PORTS[d]; en = 1'b1; wr_in = w; addr_in = a; data_in = wd;
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (ready_a[d]) begin
                lat = k;
                break;
            end
        end
        chk("latency", 128'(lat), 128'(2 + WAITS[d]));
        g = exp_q.pop_front();
        if (lat != 0) begin
            chk("rdata",   128'(rdata_a[g.dut]), 128'(g.rdata));
            chk("slv_err", 128'(err_a[g.dut]),   128'(g.err));
            chk("regs",    regs_a[g.dut],        flat(g.dut));
        end
        @(negedge clk);
        chk("ready_width", 128'(ready_a[d]), 128'(0));
        chk("rdata_clr",   128'(rdata_a[d]), 128'(0));
        data_in = ~wd;
        addr_in = a ^ 12'h004;
        repeat (hold) @(negedge clk);
        en = 1'b0; sel_port = 3'd0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk("pulses", 128'(ready_cnt[i] - c0[i]), 128'((i == d) ? 1 : 0));
        chk("regs_after", regs_a[d], flat(d));
    endtask

    initial begin
        int c0 [3];
        int d;
        logic [5:0] idx;
        logic [1:0] lo;
        rst = 1'b0; sel_port = 3'd0; en = 1'b0; wr_in = 1'b0;
        addr_in = 12'h0; data_in = 32'h0; sts_in = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_idle_all("reset");
        rst = 1'b1;

        // Write / read-back on the zero-wait port
        xfer(0, 1'b1, 12'h204, 32'hDEAD_BEEF, 0);
        chk("reg1_deadbeef", 128'(regs_a[0][63:32]), 128'(32'hDEAD_BEEF));
        xfer(0, 1'b0, 12'h204, 32'h0, 0);

        // Wait states: reset value readback with 3 wait states
        xfer(1, 1'b0, 12'h400, 32'h0, 0);

        // Status word and error cases
        sts_in = 32'h1234_5678;
        xfer(0, 1'b0, 12'h210, 32'h0, 0);
        xfer(0, 1'b1, 12'h210, 32'h5A5A_5A5A, 0);
        xfer(0, 1'b0, 12'h214, 32'h0, 0);
        xfer(0, 1'b0, 12'h202, 32'h0, 0);
        xfer(0, 1'b1, 12'h20C, 32'h0BAD_F00D, 0);

        // Random mix across all three completers
        for (int n = 0; n < 24; n++) begin
            d   = int'($urandom_range(0, 2));
            idx = 6'($urandom_range(0, 5));
            lo  = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00;
            sts_in = $urandom;
            xfer(d, 1'($urandom_range(0, 1)), {1'b0, PORTS[d], idx, lo}, $urandom, 0);
        end

        // Port miss: nobody responds to sel_port=3
        for (int i = 0; i < 3; i++) c0[i] = ready_cnt[i];
        @(negedge clk);
        sel_port = 3'd3; en = 1'b1; wr_in = 1'b1; addr_in = 12'h300; data_in = 32'hFFFF_FFFF;
        repeat (8) @(negedge clk);
        en = 1'b0; sel_port = 3'd0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk("miss_pulses", 128'(ready_cnt[i] - c0[i]), 128'(0));
        check_idle_all("miss");

        // Abort: drop en during WAIT on the 4-wait port
        xfer(2, 1'b1, 12'h500, 32'h1357_9BDF, 0);
        for (int i = 0; i < 3; i++) c0[i] = ready_cnt[i];
        @(negedge clk);
        sel_port = 3'd5; en = 1'b1; wr_in = 1'b1; addr_in = 12'h504; data_in = 32'h2468_ACE0;
        repeat (3) @(negedge clk);
        en = 1'b0; sel_port = 3'd0;
        repeat (10) @(negedge clk);
        chk("abort_pulses", 128'(ready_cnt[2] - c0[2]), 128'(0));
        chk("abort_regs", regs_a[2], flat(2));

        // Reset in WAIT discards the pending write and clears everything
        @(negedge clk);
        sel_port = 3'd5; en = 1'b1; wr_in = 1'b1; addr_in = 12'h508; data_in = 32'hFACE_0001;
        @(posedge clk); @(posedge clk);
        #1;
        rst = 1'b0; en = 1'b0; sel_port = 3'd0;
        @(posedge clk);
        #1;
        model_reset();
        check_idle_all("midrst");
        rst = 1'b1;
        for (int i = 0; i < 3; i++) c0[i] = ready_cnt[i];
        repeat (10) @(negedge clk);
        chk("midrst_pulses", 128'(ready_cnt[2] - c0[2]), 128'(0));

        // Held en: exactly one pulse, one write
        xfer(0, 1'b1, 12'h208, 32'hA1B2_C3D4, 10);
        chk("held_reg2", 128'(regs_a[0][95:64]), 128'(32'hA1B2_C3D4));
        xfer(0, 1'b0, 12'h208, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
